// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts RV32I load/store requests, drives a ready-handshaked
// data memory with lane-aligned enables/data, extends load data and flags faults.
module lsu_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic misaligned_f(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic illegal_f(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 >= 3'b011);
        end else begin
            return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
    endfunction

    function automatic logic [3:0] be_f(input logic we, input logic [2:0] f3, input logic [1:0] off);
        if (!we) begin
            return 4'b1111;
        end else begin
            case (f3)
                3'b000:  return 4'b0001 << off;
                3'b001:  return 4'b0011 << off;
                default: return 4'b1111;
            endcase
        end
    endfunction

    function automatic logic [31:0] wdata_f(input logic we, input logic [2:0] f3, input logic [31:0] wd);
        if (!we) begin
            return 32'h0000_0000;
        end else begin
            case (f3)
                3'b000:  return {4{wd[7:0]}};
                3'b001:  return {2{wd[15:0]}};
                default: return wd;
            endcase
        end
    endfunction

    function automatic logic [31:0] extract_f(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
        logic [31:0] w;
        w = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b100:  return {24'h00_0000, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b101:  return {16'h0000, w[15:0]};
            default: return w;
        endcase
    endfunction

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [2:0]    f3_r, f3_s;
    logic [1:0]    off_r, off_s;
    logic          done_r, done_s;
    logic          err_r, err_s;
    logic [31:0]   rdata_r, rdata_s;
    logic          mem_req_r, mem_req_s;
    logic          mem_we_r, mem_we_s;
    logic [31:0]   mem_addr_r, mem_addr_s;
    logic [3:0]    mem_be_r, mem_be_s;
    logic [31:0]   mem_wdata_r, mem_wdata_s;
    logic          bad_s;
    logic          in_req_s;
    logic          accept_s;

    // Next-state and next-register computation for the sequencer
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        f3_s     = f3_r;
        off_s    = off_r;
        rdata_s  = rdata_r;
        err_s    = 1'b0;
        bad_s    = illegal_f(req_we, req_funct3) || misaligned_f(req_funct3, req_addr[1:0]);
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    if (bad_s) begin
                        state_s = ST_DONE;
                        err_s   = 1'b1;
                    end else begin
                        state_s = ST_REQ;
                        cnt_s   = '0;
                        f3_s    = req_funct3;
                        off_s   = req_addr[1:0];
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // A ready in the final counted cycle still completes normally
                if (mem_ready) begin
                    state_s = ST_DONE;
                    if (!mem_we_r) begin
                        rdata_s = extract_f(f3_r, off_r, mem_rdata);
                    end else begin
                        rdata_s = rdata_r;
                    end
                end else if (TO_EN && (cnt_r == TO_LAST)) begin
                    state_s = ST_DONE;
                    err_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        done_s   = (state_s == ST_DONE);
        in_req_s = (state_s == ST_REQ);
        accept_s = (state_r == ST_IDLE);
        mem_req_s   = in_req_s;
        mem_we_s    = in_req_s ? (accept_s ? req_we : mem_we_r) : 1'b0;
        mem_addr_s  = in_req_s ? (accept_s ? {req_addr[31:2], 2'b00} : mem_addr_r) : 32'h0000_0000;
        mem_be_s    = in_req_s ? (accept_s ? be_f(req_we, req_funct3, req_addr[1:0]) : mem_be_r)
                               : 4'b0000;
        mem_wdata_s = in_req_s ? (accept_s ? wdata_f(req_we, req_funct3, req_wdata) : mem_wdata_r)
                               : 32'h0000_0000;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            f3_r        <= 3'b000;
            off_r       <= 2'b00;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            rdata_r     <= 32'h0000_0000;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            f3_r        <= f3_s;
            off_r       <= off_s;
            done_r      <= done_s;
            err_r       <= err_s;
            rdata_r     <= rdata_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_be_r    <= mem_be_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    assign stall     = req_valid & ~done_r;
    assign done      = done_r;
    assign err       = err_r;
    assign rdata     = rdata_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_be    = mem_be_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: hand-computed vectors for stores, extended loads,
// wait states, faults, timeout boundary and reset during an access.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    int          got_cyc, got_nreq;
    logic        got_err, got_leak, got_stall0, got_stall_done, got_done_after, got_we;
    logic [3:0]  got_be;
    logic [31:0] got_addr, got_wd, got_rdata;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .err(err), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one access; memory raises ready in cycle waits+1 after acceptance.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input int waits);
        bit fin;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
        req_wdata = wd; mem_rdata = rd; mem_ready = 1'b0;
        #1 got_stall0 = stall;
        fin = 1'b0; got_cyc = -1; got_nreq = 0; got_leak = 1'b0; got_err = 1'bx;
        got_be = 4'h0; got_addr = 32'h0; got_wd = 32'h0; got_we = 1'b0;
        for (int c = 1; c <= 40 && !fin; c++) begin
            @(negedge clk);
            if (done) begin
                got_cyc = c; got_err = err; got_stall_done = stall; got_rdata = rdata;
                fin = 1'b1;
            end else begin
                if (err) got_leak = 1'b1;
                if (mem_req) got_nreq++;
                if (c == 1) begin
                    got_be = mem_be; got_addr = mem_addr; got_wd = mem_wdata; got_we = mem_we;
                end
                mem_ready = (c == waits + 1);
            end
        end
        req_valid = 1'b0; mem_ready = 1'b0;
        chk("done_seen", 32'(fin), 32'd1);
        @(negedge clk);
        got_done_after = done;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        #12;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_be", 32'(mem_be), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // SW 0x100, zero wait
        access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        chk("sw_cyc", got_cyc, 32'd2);
        chk("sw_err", 32'(got_err), 32'd0);
        chk("sw_be", 32'(got_be), 32'hF);
        chk("sw_addr", got_addr, 32'h100);
        chk("sw_wd", got_wd, 32'hDEADBEEF);
        chk("sw_we", 32'(got_we), 32'd1);
        chk("sw_nreq", got_nreq, 32'd1);
        chk("sw_stall0", 32'(got_stall0), 32'd1);
        chk("sw_stall_done", 32'(got_stall_done), 32'd0);
        chk("sw_done_after", 32'(got_done_after), 32'd0);

        access(1'b0, 3'b000, 32'h203, 32'h0, 32'h80112233, 0);
        chk("lb_rdata", got_rdata, 32'hFFFFFF80);
        chk("lb_addr", got_addr, 32'h200);
        chk("lb_be", 32'(got_be), 32'hF);
        chk("lb_we", 32'(got_we), 32'd0);
        chk("lb_cyc", got_cyc, 32'd2);

        access(1'b0, 3'b100, 32'h203, 32'h0, 32'h80112233, 0);
        chk("lbu_rdata", got_rdata, 32'h00000080);

        access(1'b0, 3'b101, 32'h202, 32'h0, 32'hABCD1234, 3);
        chk("lhu_rdata", got_rdata, 32'h0000ABCD);
        chk("lhu_cyc", got_cyc, 32'd5);
        chk("lhu_nreq", got_nreq, 32'd4);
        chk("lhu_err", 32'(got_err), 32'd0);

        access(1'b1, 3'b001, 32'h101, 32'h1234, 32'h0, 0);
        chk("sh_mis_cyc", got_cyc, 32'd1);
        chk("sh_mis_err", 32'(got_err), 32'd1);
        chk("sh_mis_nreq", got_nreq, 32'd0);
        chk("sh_mis_rdata_hold", got_rdata, 32'h0000ABCD);

        access(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
        chk("lw_mis_cyc", got_cyc, 32'd1);
        chk("lw_mis_err", 32'(got_err), 32'd1);
        chk("lw_mis_nreq", got_nreq, 32'd0);

        access(1'b0, 3'b011, 32'h200, 32'h0, 32'h0, 0);
        chk("ld_ill_cyc", got_cyc, 32'd1);
        chk("ld_ill_err", 32'(got_err), 32'd1);

        access(1'b1, 3'b011, 32'h200, 32'h0, 32'h0, 0);
        chk("st_ill_err", 32'(got_err), 32'd1);
        chk("st_ill_nreq", got_nreq, 32'd0);

        access(1'b1, 3'b000, 32'h3, 32'h000000A5, 32'h0, 0);
        chk("sb_be", 32'(got_be), 32'h8);
        chk("sb_wd", got_wd, 32'hA5A5A5A5);
        chk("sb_addr", got_addr, 32'h0);

        access(1'b1, 3'b001, 32'h302, 32'h1234BEEF, 32'h0, 0);
        chk("sh_be", 32'(got_be), 32'hC);
        chk("sh_wd", got_wd, 32'hBEEFBEEF);

        access(1'b0, 3'b001, 32'h306, 32'h0, 32'h80017F00, 0);
        chk("lh_rdata", got_rdata, 32'hFFFF8001);

        access(1'b0, 3'b010, 32'h400, 32'h0, 32'h12345678, 1);
        chk("lw_rdata", got_rdata, 32'h12345678);
        chk("lw_cyc", got_cyc, 32'd3);

        // Ready arrives in the last cycle before timeout: normal completion
        access(1'b0, 3'b010, 32'h700, 32'h0, 32'hCAFEF00D, 15);
        chk("edge_cyc", got_cyc, 32'd17);
        chk("edge_err", 32'(got_err), 32'd0);
        chk("edge_rdata", got_rdata, 32'hCAFEF00D);
        chk("edge_nreq", got_nreq, 32'd16);

        access(1'b0, 3'b010, 32'h500, 32'h0, 32'h11111111, 1000);
        chk("to_nreq", got_nreq, 32'd16);
        chk("to_cyc", got_cyc, 32'd17);
        chk("to_err", 32'(got_err), 32'd1);
        chk("to_rdata_hold", got_rdata, 32'hCAFEF00D);
        chk("to_idle", 32'(got_done_after), 32'd0);
        chk("err_only_with_done", 32'(got_leak), 32'd0);

        // Reset asserted while the memory request is outstanding
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h600;
        @(negedge clk);
        chk("rstreq_mem_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstreq_mem_req_lo", 32'(mem_req), 32'd0);
        chk("rstreq_done", 32'(done), 32'd0);
        chk("rstreq_err", 32'(err), 32'd0);
        chk("rstreq_rdata", rdata, 32'h0);
        @(negedge clk); req_valid = 1'b0; rst_n = 1'b1;

        access(1'b1, 3'b000, 32'h801, 32'h0000003C, 32'h0, 0);
        chk("post_sb_cyc", got_cyc, 32'd2);
        chk("post_sb_err", 32'(got_err), 32'd0);
        chk("post_sb_be", 32'(got_be), 32'h2);
        chk("post_sb_wd", got_wd, 32'h3C3C3C3C);
        chk("post_sb_addr", got_addr, 32'h800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
